wb_serial_tx_slave: RTL and testbench

WB_SERIAL_TX_SLAVE -- requirements
Module: wb_serial_tx_slave

---
 rtl/wb_serial_tx_slave.sv | 135 +++++++++++++
 tb/tb_wb_serial_tx_slave.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_serial_tx_slave.sv
// Wishbone slave that serialises NBITS-wide words LSB first on data_o,
// framed by ena_o, with a programmable bit period and a frame counter.
module wb_serial_tx_slave #(
    parameter int unsigned NBITS   = 10,
    parameter int unsigned DIV_RST = 3
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    output logic        ena_o,
    output logic        data_o
);

    localparam int unsigned IdxW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBITS - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

    state_e             state_q;
    logic [NBITS-1:0]   shift_q;
    logic [IdxW-1:0]    bit_idx_q;
    logic [15:0]        bit_cnt_q;
    logic [15:0]        div_q;
    logic [7:0]         frame_cnt_q;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;
    logic               ack_done_q, ack_done_d;
    logic               ena_q, data_q;

    logic               req, busy, data_wr, data_accept, div_wr;
    logic [1:0]         addr;
    logic [31:0]        rd_data;
    logic [NBITS-1:0]   shift_nxt;
    logic               unused_bits;

    assign unused_bits = ^{ADR_I[31:4], ADR_I[1:0], DAT_I};

    // Request decode, ACK/stall decision and read mux.
    always_comb begin
        addr        = ADR_I[3:2];
        req         = CYC_I & STB_I & ~ack_done_q;
        busy        = (state_q != StIdle);
        data_wr     = req & WE_I & (addr == 2'd0);
        // A DATA write is held off (no ACK) until the frame in flight finishes.
        ack_d       = req & ~(data_wr & busy);
        data_accept = data_wr & ~busy;
        div_wr      = req & WE_I & (addr == 2'd1);
        case (addr)
            2'd1:    rd_data = {16'h0000, div_q};
            2'd2:    rd_data = {16'h0000, frame_cnt_q, 7'h00, busy};
            default: rd_data = 32'h0000_0000;
        endcase
        dat_d      = (ack_d & ~WE_I) ? rd_data : 32'h0000_0000;
        // Remembers that this strobe was answered until the master releases it.
        ack_done_d = CYC_I & STB_I & (ack_done_q | ack_d);
        shift_nxt  = shift_q >> 1;
    end

    // Bus-side registers: ACK, read data, ack_done and the DIV register.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            ack_q      <= 1'b0;
            dat_q      <= 32'h0000_0000;
            ack_done_q <= 1'b0;
            div_q      <= 16'(DIV_RST);
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            ack_done_q <= ack_done_d;
            if (div_wr) begin
                div_q <= DAT_I[15:0];
            end
        end
    end

    // Transmit FSM with registered ena/data outputs.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            bit_cnt_q   <= 16'h0000;
            frame_cnt_q <= 8'h00;
            ena_q       <= 1'b0;
            data_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (data_accept) begin
                        shift_q <= DAT_I[NBITS-1:0];
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    state_q   <= StShift;
                    bit_cnt_q <= div_q;
                    bit_idx_q <= '0;
                    ena_q     <= 1'b1;
                    data_q    <= shift_q[0];
                end
                StShift: begin
                    if (bit_cnt_q == 16'h0000) begin
                        if (bit_idx_q == LastIdx) begin
                            state_q     <= StIdle;
                            ena_q       <= 1'b0;
                            data_q      <= 1'b0;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end else begin
                            // DIV is re-sampled at every bit start.
                            shift_q   <= shift_nxt;
                            data_q    <= shift_nxt[0];
                            bit_idx_q <= bit_idx_q + 1'b1;
                            bit_cnt_q <= div_q;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ACK_O  = ack_q;
    assign DAT_O  = dat_q;
    assign ena_o  = ena_q;
    assign data_o = data_q;

endmodule

// File: tb/tb_wb_serial_tx_slave.sv
// Scoreboard bench for wb_serial_tx_slave: stimulus pushes expected ACK data
// and expected frames; a negedge monitor pops and compares.
module tb_wb_serial_tx_slave;

    localparam int NB = 10;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;
    logic        CYC_I = 1'b0;
    logic        STB_I = 1'b0;
    logic        WE_I  = 1'b0;
    logic [31:0] ADR_I = 32'h0;
    logic [31:0] DAT_I = 32'h0;
    logic [31:0] DAT_O;
    logic        ACK_O;
    logic        ena_o;
    logic        data_o;

    wb_serial_tx_slave #(.NBITS(NB), .DIV_RST(3)) dut (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .CYC_I  (CYC_I),
        .STB_I  (STB_I),
        .WE_I   (WE_I),
        .ADR_I  (ADR_I),
        .DAT_I  (DAT_I),
        .DAT_O  (DAT_O),
        .ACK_O  (ACK_O),
        .ena_o  (ena_o),
        .data_o (data_o)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct {
        logic [31:0] dat;
        string       name;
    } ack_t;

    typedef struct {
        logic [31:0] word;
        int          div;
    } frame_t;

    ack_t   exp_acks[$];
    frame_t exp_frames[$];
    bit     samples[$];
    int     checks = 0;
    int     failures = 0;
    int     frames_done = 0;
    bit     collecting = 0;

    ack_t   a;
    frame_t f;
    int     bad, per;

    // Monitor: compares ACK data and completed frames against the queues.
    always @(negedge CLK_I) begin
        if (!RST_I) begin
            exp_frames.delete();
            samples.delete();
            collecting = 0;
        end else begin
            if (ACK_O) begin
                checks++;
                if (exp_acks.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ack: got ACK with DAT_O=%h, none expected", DAT_O);
                end else begin
                    a = exp_acks.pop_front();
                    if (DAT_O !== a.dat) begin
                        failures++;
                        $display("FAIL ack_%s: DAT_O=%h expected %h", a.name, DAT_O, a.dat);
                    end
                end
            end
            if (ena_o) begin
                collecting = 1;
                samples.push_back(data_o);
            end else begin
                checks++;
                if (data_o !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_data: data_o=%b expected 0 while ena_o=0", data_o);
                end
                if (collecting) begin
                    collecting = 0;
                    frames_done++;
                    checks++;
                    if (exp_frames.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_frame: %0d clocks, none expected",
                                 samples.size());
                    end else begin
                        f   = exp_frames.pop_front();
                        per = f.div + 1;
                        if (samples.size() != NB * per) begin
                            failures++;
                            $display("FAIL frame_len: ena_o high %0d clocks expected %0d",
                                     samples.size(), NB * per);
                        end
                        checks++;
                        bad = 0;
                        for (int i = 0; i < samples.size() && i < NB * per; i++) begin
                            if (samples[i] !== f.word[i / per]) bad++;
                        end
                        if (bad != 0) begin
                            failures++;
                            $display("FAIL frame_bits: word %h div %0d, %0d wrong samples",
                                     f.word, f.div, bad);
                        end
                    end
                    samples.delete();
                end
            end
        end
    end

    // One Wishbone transfer; hold keeps STB_I high extra cycles after ACK.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [31:0] exp_rd, input string nm, input int hold,
                           output int lat);
        bit got;
        ack_t e;
        e.dat  = exp_rd;
        e.name = nm;
        exp_acks.push_back(e);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat;
        lat = 0;
        got = 0;
        while (!got && lat < 3000) begin
            @(posedge CLK_I); #1;
            lat++;
            if (ACK_O) got = 1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout_%s: no ACK after %0d cycles, ACK required", nm, lat);
            exp_acks.delete();
        end
        repeat (hold) @(posedge CLK_I);
        #1;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        @(posedge CLK_I); #1;
    endtask

    task automatic push_frame(input logic [31:0] w, input int d);
        frame_t fr;
        fr.word = w;
        fr.div  = d;
        exp_frames.push_back(fr);
    endtask

    task automatic wait_frames(input int n);
        int c = 0;
        while (frames_done < n && c < 5000) begin
            @(posedge CLK_I);
            c++;
        end
        #1;
        checks++;
        if (frames_done < n) begin
            failures++;
            $display("FAIL frame_timeout: frames_done=%0d expected %0d", frames_done, n);
        end
    endtask

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    int lat;
    int nf;

    initial begin
        // Reset state.
        repeat (3) @(posedge CLK_I);
        #1;
        check_val("rst_ack", {31'h0, ACK_O}, 32'h0);
        check_val("rst_dat", DAT_O, 32'h0);
        check_val("rst_ena", {31'h0, ena_o}, 32'h0);
        check_val("rst_data", {31'h0, data_o}, 32'h0);
        RST_I = 1'b1;
        @(posedge CLK_I); #1;

        // Reads: reset DIV and idle STATUS, one wait state.
        wb_xfer(0, 32'h4, 32'h0, 32'h0000_0003, "rd_div_rst", 0, lat);
        check_val("rd_latency", lat, 1);
        wb_xfer(0, 32'h8, 32'h0, 32'h0000_0000, "rd_status_rst", 0, lat);
        wb_xfer(0, 32'h0, 32'h0, 32'h0000_0000, "rd_data_reg", 0, lat);

        // Single write: 0x201 LSB first, DIV=3 -> 40 clocks.
        push_frame(32'h0000_0201, 3);
        wb_xfer(1, 32'h0, 32'h0003_0201, 32'h0, "wr_single", 0, lat);
        check_val("wr_idle_latency", lat, 1);
        wb_xfer(0, 32'h8, 32'h0, 32'h0000_0001, "status_busy", 0, lat);
        wait_frames(1);
        wb_xfer(0, 32'h8, 32'h0, 32'h0000_0100, "status_cnt1", 0, lat);

        // Reset in the middle of a frame.
        push_frame(32'h0000_03C3, 3);
        wb_xfer(1, 32'h0, 32'h0000_03C3, 32'h0, "wr_pre_reset", 0, lat);
        repeat (8) @(posedge CLK_I);
        #3;
        check_val("midframe_ena", {31'h0, ena_o}, 32'h1);
        RST_I = 1'b0;
        #1;
        check_val("reset_ena", {31'h0, ena_o}, 32'h0);
        check_val("reset_data", {31'h0, data_o}, 32'h0);
        check_val("reset_ack", {31'h0, ACK_O}, 32'h0);
        repeat (3) @(posedge CLK_I);
        #1;
        RST_I = 1'b1;
        nf = frames_done;
        @(posedge CLK_I); #1;
        wb_xfer(0, 32'h8, 32'h0, 32'h0000_0000, "status_after_rst", 0, lat);

        // Held strobe: one ACK, one frame.
        push_frame(32'h0000_0155, 3);
        wb_xfer(1, 32'h0, 32'h0000_0155, 32'h0, "wr_held", 5, lat);
        wait_frames(nf + 1);
        wb_xfer(0, 32'h8, 32'h0, 32'h0000_0100, "status_held", 0, lat);

        // Back-to-back: second write stalls until the first frame ends.
        push_frame(32'h0000_02AA, 3);
        push_frame(32'h0000_03FF, 3);
        wb_xfer(1, 32'h0, 32'h0000_02AA, 32'h0, "wr_b2b_1", 0, lat);
        wb_xfer(1, 32'h0, 32'h0000_03FF, 32'h0, "wr_b2b_2", 0, lat);
        checks++;
        if (lat < 40) begin
            failures++;
            $display("FAIL stall_latency: ACK after %0d cycles, at least 40 required", lat);
        end
        wait_frames(nf + 3);

        // Stalled write abandoned by dropping CYC: no ACK, no frame.
        push_frame(32'h0000_00F0, 3);
        wb_xfer(1, 32'h0, 32'h0000_00F0, 32'h0, "wr_before_abort", 0, lat);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 32'h0; DAT_I = 32'h111;
        repeat (5) @(posedge CLK_I);
        #1;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        wait_frames(nf + 4);
        repeat (60) @(posedge CLK_I);
        #1;
        check_val("abort_no_frame", frames_done, nf + 4);
        wb_xfer(0, 32'h8, 32'h0, 32'h0000_0400, "status_abort", 0, lat);

        // DIV = 0: one clock per bit.
        wb_xfer(1, 32'h4, 32'h0000_0000, 32'h0, "wr_div0", 0, lat);
        wb_xfer(0, 32'h4, 32'h0, 32'h0000_0000, "rd_div0", 0, lat);
        push_frame(32'h0000_02CB, 0);
        wb_xfer(1, 32'h0, 32'h0000_02CB, 32'h0, "wr_div0_frame", 0, lat);
        wait_frames(nf + 5);

        // Frame counter wrap: 5 frames so far, 250 more -> 255, then 256 -> 0.
        for (int i = 0; i < 250; i++) begin
            push_frame((i * 37) & 32'h3FF, 0);
            wb_xfer(1, 32'h0, (i * 37) & 32'h3FF, 32'h0, "wr_wrap", 0, lat);
            wait_frames(nf + 6 + i);
        end
        wb_xfer(0, 32'h8, 32'h0, 32'h0000_FF00, "status_255", 0, lat);
        push_frame(32'h0000_0001, 0);
        wb_xfer(1, 32'h0, 32'h0000_0001, 32'h0, "wr_wrap_last", 0, lat);
        wait_frames(nf + 256);
        wb_xfer(0, 32'h8, 32'h0, 32'h0000_0000, "status_wrap", 0, lat);

        // Unmapped: reads 0, writes ignored.
        wb_xfer(0, 32'hC, 32'h0, 32'h0000_0000, "rd_unmapped", 0, lat);
        wb_xfer(1, 32'hC, 32'hFFFF_FFFF, 32'h0, "wr_unmapped", 0, lat);
        wb_xfer(0, 32'h4, 32'h0, 32'h0000_0000, "rd_div_after_unmapped", 0, lat);
        wb_xfer(0, 32'h8, 32'h0, 32'h0000_0000, "status_after_unmapped", 0, lat);

        repeat (5) @(posedge CLK_I);
        checks++;
        if (exp_acks.size() != 0 || exp_frames.size() != 0) begin
            failures++;
            $display("FAIL leftover: %0d acks and %0d frames outstanding, 0 required",
                     exp_acks.size(), exp_frames.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
